// File: rtl/cache_pkg.sv
// Shared cache parameters and tree-PLRU node helpers for the L2 lookup path.
package cache_pkg;

    localparam int unsigned WAYS_DEFAULT       = 8;
    localparam int unsigned INDEX_BITS_DEFAULT = 14;
    localparam int unsigned COUNT_BITS_DEFAULT = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } plru_state_e;

    function automatic int unsigned way_bits(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    // Heap-ordered tree: root 0, children of n are 2n+1 (lower) and 2n+2 (upper).
    function automatic int unsigned node_parent(input int unsigned n);
        return (n - 1) / 2;
    endfunction

    function automatic int unsigned node_child(input int unsigned n, input logic upper);
        return 2 * n + 1 + 32'(upper);
    endfunction

    // Node visited at a given level on the path from the root to way w.
    function automatic int unsigned path_node(input int unsigned w, input int unsigned level,
                                              input int unsigned levels);
        return ((1 << level) - 1) + (w >> (levels - level));
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU: victim traversal and touch update for one set.
module plru_tree
    import cache_pkg::*;
#(
    parameter int unsigned ways = WAYS_DEFAULT,
    localparam int unsigned wayBits = way_bits(ways)
) (
    input  logic [ways-2:0]    state,
    input  logic [wayBits-1:0] way,
    output logic [wayBits-1:0] victim,
    output logic [ways-2:0]    next_state
);

    localparam int unsigned levels = $clog2(ways);

    // Follow node bits from the root; each bit chooses the half holding the victim.
    always_comb begin
        int unsigned node;
        victim = '0;
        node   = 0;
        for (int l = 0; l < int'(levels); l++) begin
            victim[int'(levels) - 1 - l] = state[node];
            node = node_child(node, state[node]);
        end
    end

    // Every node on the path to the touched way is pointed at the other half.
    always_comb begin
        next_state = state;
        for (int l = 0; l < int'(levels); l++) begin
            next_state[path_node(32'(way), 32'(l), levels)] = ~way[int'(levels) - 1 - l];
        end
    end

endmodule

// File: rtl/plru_replacer.sv
// L2 replacement stage: picks hit way or fill victim, keeps per-set tree-PLRU and statistics.
module plru_replacer
    import cache_pkg::*;
#(
    parameter int unsigned ways      = WAYS_DEFAULT,
    parameter int unsigned indexBits = INDEX_BITS_DEFAULT,
    parameter int unsigned countBits = COUNT_BITS_DEFAULT,
    localparam int unsigned wayBits  = way_bits(ways)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic [indexBits-1:0] reqIndex,
    input  logic                 reqHit,
    input  logic [wayBits-1:0]   reqHitWay,
    input  logic [ways-1:0]      reqValidBits,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [wayBits-1:0]   respWay,
    output logic                 respHit,
    output logic                 respEvict,
    output logic                 initDone,
    output logic                 protocolError,
    output logic [countBits-1:0] hitCount,
    output logic [countBits-1:0] missCount,
    output logic [countBits-1:0] evictCount
);

    localparam int unsigned sets = 1 << indexBits;

    plru_state_e          state;
    logic [indexBits-1:0] clear_ptr;
    logic [ways-2:0]      plru_mem [sets];
    logic [ways-2:0]      cur_bits;
    logic [ways-2:0]      new_bits;
    logic [wayBits-1:0]   tree_victim;
    logic [wayBits-1:0]   low_invalid;
    logic [wayBits-1:0]   sel_way;
    logic                 any_invalid;
    logic                 sel_evict;
    logic                 bad_hit;
    logic                 accept;

    function automatic logic [countBits-1:0] sat_inc(input logic [countBits-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign reqReady = (state == ST_RUN) && (!respValid || respReady);
    assign accept   = reqValid && reqReady;
    assign cur_bits = plru_mem[reqIndex];
    assign bad_hit  = reqHit && !reqValidBits[reqHitWay];

    plru_tree #(.ways(ways)) u_tree (
        .state      (cur_bits),
        .way        (sel_way),
        .victim     (tree_victim),
        .next_state (new_bits)
    );

    // Lowest-numbered invalid way wins a fill over the PLRU victim.
    always_comb begin
        low_invalid = '0;
        any_invalid = 1'b0;
        for (int i = int'(ways) - 1; i >= 0; i--) begin
            if (!reqValidBits[i]) begin
                low_invalid = wayBits'(i);
                any_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_way   = tree_victim;
        sel_evict = 1'b0;
        if (reqHit) begin
            sel_way = reqHitWay;
        end else if (any_invalid) begin
            sel_way = low_invalid;
        end else begin
            sel_evict = 1'b1;
        end
    end

    // State array: swept to zero during INIT, touched on every accept afterwards.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            plru_mem[clear_ptr] <= '0;
        end else if (accept) begin
            plru_mem[reqIndex] <= new_bits;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_INIT;
            clear_ptr     <= '0;
            initDone      <= 1'b0;
            respValid     <= 1'b0;
            respWay       <= '0;
            respHit       <= 1'b0;
            respEvict     <= 1'b0;
            protocolError <= 1'b0;
            hitCount      <= '0;
            missCount     <= '0;
            evictCount    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == '1) begin
                        state    <= ST_RUN;
                        initDone <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (respValid && respReady) begin
                        respValid <= 1'b0;
                    end
                    if (accept) begin
                        respValid <= 1'b1;
                        respWay   <= sel_way;
                        respHit   <= reqHit;
                        respEvict <= sel_evict;
                        if (bad_hit) begin
                            protocolError <= 1'b1;
                        end
                        if (reqHit) begin
                            hitCount <= sat_inc(hitCount);
                        end else begin
                            missCount <= sat_inc(missCount);
                        end
                        if (sel_evict) begin
                            evictCount <= sat_inc(evictCount);
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
